// File: rtl/core_v_mcu_reg_pkg.sv
// rtl/core_v_mcu_reg_pkg.sv - register-interface request/response types of the bus subsystem
package core_v_mcu_reg_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_resp_t;

endpackage

// File: rtl/prio_intr_ctrl_pkg.sv
// rtl/prio_intr_ctrl_pkg.sv - register map and sizing helpers for the prioritised interrupt controller
package prio_intr_ctrl_pkg;

    localparam int MaxSources   = 32;
    localparam int RegDataWidth = 32;
    localparam int DecodeWidth  = 8;

    localparam logic [DecodeWidth-1:0] OffPending   = 8'h00;
    localparam logic [DecodeWidth-1:0] OffEnable    = 8'h04;
    localparam logic [DecodeWidth-1:0] OffMode      = 8'h08;
    localparam logic [DecodeWidth-1:0] OffThreshold = 8'h0C;
    localparam logic [DecodeWidth-1:0] OffClaim     = 8'h10;
    localparam logic [DecodeWidth-1:0] OffComplete  = 8'h14;
    localparam logic [DecodeWidth-1:0] OffInService = 8'h18;
    localparam int                     PrioBaseWord = 16;

    function automatic int IdWidth(input int num_sources);
        return $clog2(num_sources + 1);
    endfunction

endpackage

// File: rtl/prio_intr_arbiter.sv
// rtl/prio_intr_arbiter.sv - combinational comparison tree picking the highest-priority valid source
module prio_intr_arbiter #(
    parameter int NumSources = 16,
    parameter int PrioWidth  = 3,
    parameter int IdxW       = (NumSources > 1) ? $clog2(NumSources) : 1
) (
    input  logic [NumSources-1:0]                valid_i,
    input  logic [NumSources-1:0][PrioWidth-1:0] prio_i,
    output logic                                 win_valid_o,
    output logic [PrioWidth-1:0]                 win_prio_o,
    output logic [IdxW-1:0]                      win_idx_o
);

    localparam int Levels = (NumSources > 1) ? $clog2(NumSources) : 0;
    localparam int Leaves = 1 << Levels;
    localparam int Nodes  = 2 * Leaves - 1;

    logic [Nodes-1:0]                node_valid;
    logic [Nodes-1:0][PrioWidth-1:0] node_prio;
    logic [Nodes-1:0][IdxW-1:0]      node_idx;

    // Heap layout: leaves in index order, so a left child always holds lower indices
    // and a >= comparison hands ties to the lower index.
    always_comb begin
        node_valid = '0;
        node_prio  = '0;
        node_idx   = '0;
        for (int i = 0; i < NumSources; i++) begin
            node_valid[Leaves-1+i] = valid_i[i];
            node_prio[Leaves-1+i]  = prio_i[i];
            node_idx[Leaves-1+i]   = IdxW'(i);
        end
        for (int j = Leaves - 2; j >= 0; j--) begin
            if (node_valid[2*j+1] &&
                (!node_valid[2*j+2] || node_prio[2*j+1] >= node_prio[2*j+2])) begin
                node_valid[j] = node_valid[2*j+1];
                node_prio[j]  = node_prio[2*j+1];
                node_idx[j]   = node_idx[2*j+1];
            end else begin
                node_valid[j] = node_valid[2*j+2];
                node_prio[j]  = node_prio[2*j+2];
                node_idx[j]   = node_idx[2*j+2];
            end
        end
    end

    assign win_valid_o = node_valid[0];
    assign win_prio_o  = node_prio[0];
    assign win_idx_o   = node_idx[0];

endmodule

// File: rtl/prio_intr_ctrl.sv
// rtl/prio_intr_ctrl.sv - prioritised interrupt controller with edge/level sources and claim/complete
module prio_intr_ctrl
    import prio_intr_ctrl_pkg::*;
#(
    parameter int  NumSources = 16,
    parameter int  PrioWidth  = 3,
    parameter type reg_req_t  = core_v_mcu_reg_pkg::reg_req_t,
    parameter type reg_rsp_t  = core_v_mcu_reg_pkg::reg_resp_t
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  reg_req_t                       reg_req_i,
    output reg_rsp_t                       reg_rsp_o,
    input  logic [NumSources-1:0]          intr_src_i,
    output logic [NumSources-1:0]          fast_intr_o,
    output logic                           irq_o,
    output logic [IdWidth(NumSources)-1:0] irq_id_o
);

    localparam int N    = NumSources;
    localparam int IdW  = IdWidth(NumSources);
    localparam int IdxW = (NumSources > 1) ? $clog2(NumSources) : 1;

    logic [N-1:0]                pending_q;
    logic [N-1:0]                enable_q;
    logic [N-1:0]                mode_q;
    logic [N-1:0]                in_service_q;
    logic [N-1:0]                src_q;
    logic [PrioWidth-1:0]        threshold_q;
    logic [N-1:0][PrioWidth-1:0] prio_q;
    logic [N-1:0]                fast_intr_q;
    logic                        irq_q;
    logic [IdW-1:0]              irq_id_q;

    logic [DecodeWidth-1:0]      offset;
    logic [DecodeWidth-3:0]      word_idx;
    logic                        is_prio;
    logic [IdxW-1:0]             prio_idx;
    logic [RegDataWidth-1:0]     wdata_m;
    logic [N-1:0]                wbits;
    logic [RegDataWidth-1:0]     rd_data;
    logic                        dec_err;
    logic                        we_pend, we_en, we_mode, we_thr, we_prio, we_complete, re_claim;

    logic [N-1:0]                claim_mask, complete_mask, w1c_mask, rise;
    logic [N-1:0]                pending_d, in_service_d, elig;
    logic                        win_valid;
    logic [PrioWidth-1:0]        win_prio;
    logic [IdxW-1:0]             win_idx;
    logic                        irq_d;
    logic [IdW-1:0]              irq_id_d;
    logic                        unused_req;

    assign offset   = reg_req_i.addr[DecodeWidth-1:0];
    assign word_idx = offset[DecodeWidth-1:2];
    assign is_prio  = (int'(word_idx) >= PrioBaseWord) && (int'(word_idx) < PrioBaseWord + N);
    assign prio_idx = IdxW'(int'(word_idx) - PrioBaseWord);

    always_comb begin
        wdata_m = '0;
        for (int b = 0; b < RegDataWidth; b++) begin
            wdata_m[b] = reg_req_i.wdata[b] & reg_req_i.wstrb[b/8];
        end
    end

    assign wbits      = wdata_m[N-1:0];
    assign unused_req = ^{reg_req_i.addr, wdata_m};

    // Any rejected access raises error and leaves every write/claim strobe low.
    always_comb begin
        rd_data     = '0;
        dec_err     = 1'b0;
        we_pend     = 1'b0;
        we_en       = 1'b0;
        we_mode     = 1'b0;
        we_thr      = 1'b0;
        we_prio     = 1'b0;
        we_complete = 1'b0;
        re_claim    = 1'b0;
        if (reg_req_i.valid) begin
            if (offset[1:0] != 2'b00) begin
                dec_err = 1'b1;
            end else if (is_prio) begin
                if (reg_req_i.write) we_prio = 1'b1;
                else                 rd_data = RegDataWidth'(prio_q[prio_idx]);
            end else begin
                case (offset)
                    OffPending: begin
                        if (!reg_req_i.write)          rd_data = RegDataWidth'(pending_q);
                        else if (|(wbits & ~mode_q))   dec_err = 1'b1;
                        else                           we_pend = 1'b1;
                    end
                    OffEnable: begin
                        if (reg_req_i.write) we_en = 1'b1;
                        else                 rd_data = RegDataWidth'(enable_q);
                    end
                    OffMode: begin
                        if (reg_req_i.write) we_mode = 1'b1;
                        else                 rd_data = RegDataWidth'(mode_q);
                    end
                    OffThreshold: begin
                        if (reg_req_i.write) we_thr = 1'b1;
                        else                 rd_data = RegDataWidth'(threshold_q);
                    end
                    OffClaim: begin
                        if (reg_req_i.write) begin
                            dec_err = 1'b1;
                        end else begin
                            rd_data  = RegDataWidth'(irq_id_q);
                            re_claim = 1'b1;
                        end
                    end
                    OffComplete: begin
                        if (reg_req_i.write) we_complete = 1'b1;
                        else                 dec_err     = 1'b1;
                    end
                    OffInService: begin
                        if (reg_req_i.write) dec_err = 1'b1;
                        else                 rd_data = RegDataWidth'(in_service_q);
                    end
                    default: dec_err = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = reg_req_i.valid;
        if (rst_ni) begin
            reg_rsp_o.rdata = rd_data;
            reg_rsp_o.error = dec_err;
        end
    end

    // Edge sets are OR-ed in after the clears so a same-cycle set always wins.
    always_comb begin
        claim_mask    = '0;
        complete_mask = '0;
        elig          = '0;
        for (int i = 0; i < N; i++) begin
            claim_mask[i]    = re_claim && (irq_id_q == IdW'(i + 1));
            complete_mask[i] = we_complete && (reg_req_i.wdata == RegDataWidth'(i + 1));
        end
        rise         = intr_src_i & ~src_q;
        w1c_mask     = we_pend ? (wbits & mode_q) : '0;
        pending_d    = (mode_q & ((pending_q & ~(w1c_mask | claim_mask)) | rise)) |
                       (~mode_q & intr_src_i);
        in_service_d = (in_service_q | claim_mask) & ~complete_mask;
        for (int i = 0; i < N; i++) begin
            elig[i] = pending_q[i] & enable_q[i] & ~in_service_d[i] & (prio_q[i] != '0);
        end
    end

    prio_intr_arbiter #(
        .NumSources (N),
        .PrioWidth  (PrioWidth),
        .IdxW       (IdxW)
    ) u_arbiter (
        .valid_i     (elig),
        .prio_i      (prio_q),
        .win_valid_o (win_valid),
        .win_prio_o  (win_prio),
        .win_idx_o   (win_idx)
    );

    assign irq_d    = win_valid && (win_prio > threshold_q);
    assign irq_id_d = irq_d ? (IdW'(win_idx) + IdW'(1)) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q    <= '0;
            enable_q     <= '0;
            mode_q       <= '0;
            in_service_q <= '0;
            src_q        <= '0;
            threshold_q  <= '0;
            prio_q       <= '0;
            fast_intr_q  <= '0;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
        end else begin
            src_q        <= intr_src_i;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            if (we_en)   enable_q         <= wbits;
            if (we_mode) mode_q           <= wbits;
            if (we_thr)  threshold_q      <= wdata_m[PrioWidth-1:0];
            if (we_prio) prio_q[prio_idx] <= wdata_m[PrioWidth-1:0];
            fast_intr_q  <= pending_q & enable_q & ~in_service_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
        end
    end

    assign fast_intr_o = fast_intr_q;
    assign irq_o       = irq_q;
    assign irq_id_o    = irq_id_q;

endmodule

// File: tb/tb_prio_intr_ctrl.sv
// tb/tb_prio_intr_ctrl.sv - directed self-checking bench for prio_intr_ctrl
module tb_prio_intr_ctrl;
    import core_v_mcu_reg_pkg::*;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    reg_req_t      req;
    reg_resp_t     rsp;
    logic [N-1:0]  src;
    logic [N-1:0]  fast;
    logic          irq;
    logic [4:0]    irq_id;
    int            checks = 0;
    int            errors = 0;
    logic [31:0]   rdata;
    logic          err;

    prio_intr_ctrl #(.NumSources(N), .PrioWidth(3)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .reg_req_i   (req),
        .reg_rsp_o   (rsp),
        .intr_src_i  (src),
        .fast_intr_o (fast),
        .irq_o       (irq),
        .irq_id_o    (irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e);
        @(negedge clk);
        req.addr  = addr;
        req.write = wr;
        req.wdata = wd;
        req.wstrb = 4'hF;
        req.valid = 1'b1;
        #1;
        rd = rsp.rdata;
        e  = rsp.error;
        @(negedge clk);
        req.valid = 1'b0;
        req.write = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        logic        e;
        bus(addr, 1'b1, wd, d, e);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        bus(addr, 1'b0, 32'h0, d, e);
        check(tag, d, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        src   = '0;
        req   = '0;
        tick(3);
        req.addr  = 32'h3C;
        req.valid = 1'b1;
        #1;
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_id", 32'(irq_id), 32'h0);
        check("rst_fast", 32'(fast), 32'h0);
        check("rst_rsp_err", 32'(rsp.error), 32'h0);
        check("rst_rsp_ready", 32'(rsp.ready), 32'h1);
        req.valid = 1'b0;
        tick(1);
        rst_n = 1'b1;
        rd_chk("rst_enable", 32'h04, 32'h0);
        rd_chk("rst_thr", 32'h0C, 32'h0);

        // Level source 3
        wr(32'h04, 32'h8);
        wr(32'h4C, 32'h2);
        wr(32'h0C, 32'h1);
        rd_chk("prio3_rd", 32'h4C, 32'h2);
        src[3] = 1'b1;
        tick(1);
        check("lvl_irq_lat1", 32'(irq), 32'h0);
        tick(1);
        check("lvl_irq", 32'(irq), 32'h1);
        check("lvl_id", 32'(irq_id), 32'h4);
        check("lvl_fast", 32'(fast), 32'h8);
        rd_chk("lvl_pending", 32'h00, 32'h8);
        src[3] = 1'b0;
        tick(1);
        check("lvl_drop_lat1", 32'(irq), 32'h1);
        tick(1);
        check("lvl_drop_irq", 32'(irq), 32'h0);
        check("lvl_drop_id", 32'(irq_id), 32'h0);

        // Edge sources 1 and 5, equal priority
        wr(32'h08, 32'h22);
        wr(32'h04, 32'h22);
        wr(32'h44, 32'h4);
        wr(32'h54, 32'h4);
        src = 16'h0022;
        tick(1);
        src = '0;
        tick(1);
        check("edge_irq", 32'(irq), 32'h1);
        check("edge_id", 32'(irq_id), 32'h2);
        check("edge_fast", 32'(fast), 32'h22);
        rd_chk("claim1", 32'h10, 32'h2);
        check("claim1_next_id", 32'(irq_id), 32'h6);
        check("claim1_fast", 32'(fast), 32'h20);
        rd_chk("claim2", 32'h10, 32'h6);
        check("claim2_irq", 32'(irq), 32'h0);
        check("claim2_id", 32'(irq_id), 32'h0);
        rd_chk("insvc_claimed", 32'h18, 32'h22);
        rd_chk("pend_claimed", 32'h00, 32'h0);
        wr(32'h14, 32'h2);
        wr(32'h14, 32'h6);
        rd_chk("insvc_done", 32'h18, 32'h0);
        check("done_irq", 32'(irq), 32'h0);

        // Threshold on source 0
        wr(32'h04, 32'h1);
        wr(32'h40, 32'h3);
        wr(32'h0C, 32'h3);
        src[0] = 1'b1;
        tick(3);
        check("thr_eq_irq", 32'(irq), 32'h0);
        rd_chk("thr_pending", 32'h00, 32'h1);
        wr(32'h0C, 32'h2);
        check("thr_commit_irq", 32'(irq), 32'h0);
        tick(1);
        check("thr_lt_irq", 32'(irq), 32'h1);
        check("thr_lt_id", 32'(irq_id), 32'h1);
        src[0] = 1'b0;
        tick(2);

        // Edge set versus W1C on bit 7
        wr(32'h08, 32'hA2);
        @(negedge clk);
        src[7]    = 1'b1;
        req.addr  = 32'h00;
        req.write = 1'b1;
        req.wdata = 32'h80;
        req.wstrb = 4'hF;
        req.valid = 1'b1;
        #1;
        check("w1c_race_err", 32'(rsp.error), 32'h0);
        @(negedge clk);
        req.valid = 1'b0;
        req.write = 1'b0;
        rd_chk("w1c_race_pend", 32'h00, 32'h80);
        wr(32'h00, 32'h80);
        rd_chk("w1c_clear_pend", 32'h00, 32'h0);
        src[7] = 1'b0;

        // Error responses
        bus(32'h00, 1'b1, 32'h1, rdata, err);
        check("err_w_pend_lvl", 32'(err), 32'h1);
        check("err_w_pend_rdata", rdata, 32'h0);
        bus(32'h10, 1'b1, 32'h5, rdata, err);
        check("err_w_claim", 32'(err), 32'h1);
        rd_chk("err_insvc_same", 32'h18, 32'h0);
        rd_chk("err_enable_same", 32'h04, 32'h1);
        bus(32'h3C, 1'b0, 32'h0, rdata, err);
        check("err_r_3c", 32'(err), 32'h1);
        check("err_r_3c_rdata", rdata, 32'h0);
        bus(32'h14, 1'b0, 32'h0, rdata, err);
        check("err_r_complete", 32'(err), 32'h1);
        bus(32'h80, 1'b0, 32'h0, rdata, err);
        check("err_r_prio16", 32'(err), 32'h1);

        // Mid-operation reset with three sources in service
        wr(32'h08, 32'h0);
        wr(32'h04, 32'h17);
        wr(32'h40, 32'h3);
        wr(32'h44, 32'h2);
        wr(32'h48, 32'h1);
        wr(32'h50, 32'h1);
        wr(32'h0C, 32'h0);
        src = 16'h0017;
        tick(3);
        check("mr_first_id", 32'(irq_id), 32'h1);
        rd_chk("mr_claim_a", 32'h10, 32'h1);
        rd_chk("mr_claim_b", 32'h10, 32'h2);
        rd_chk("mr_claim_c", 32'h10, 32'h3);
        check("mr_next_id", 32'(irq_id), 32'h5);
        check("mr_fast", 32'(fast), 32'h10);
        rd_chk("mr_insvc", 32'h18, 32'h7);
        rd_chk("mr_pend", 32'h00, 32'h17);
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        req.addr  = 32'h3C;
        req.valid = 1'b1;
        #1;
        check("ar_irq", 32'(irq), 32'h0);
        check("ar_id", 32'(irq_id), 32'h0);
        check("ar_fast", 32'(fast), 32'h0);
        check("ar_rsp_err", 32'(rsp.error), 32'h0);
        check("ar_rsp_rdata", rsp.rdata, 32'h0);
        check("ar_rsp_ready", 32'(rsp.ready), 32'h1);
        req.valid = 1'b0;
        src       = '0;
        tick(2);
        rst_n = 1'b1;
        rd_chk("ar_enable", 32'h04, 32'h0);
        rd_chk("ar_mode", 32'h08, 32'h0);
        rd_chk("ar_insvc", 32'h18, 32'h0);
        rd_chk("ar_pend", 32'h00, 32'h0);
        rd_chk("ar_prio0", 32'h40, 32'h0);
        check("ar_irq_after", 32'(irq), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_intr_ctrl.md
# prio_intr_ctrl

Parametrised interrupt controller that generalises the fixed 16-line fast interrupt controller. It adds a configurable source count, per-source edge/level mode, per-source priority, a global threshold and a claim/complete handshake. It sits on a `core_v_mcu_reg_pkg` register-interface slave port of the bus subsystem. It drives the core's fast IRQ vector, and also a single prioritised request with its ID.

## Interface
- `NumSources`, 16: number of interrupt sources, 1..32.
- `PrioWidth`, 3: priority field width; priority 0 means never forwarded.
- `reg_req_t`, `core_v_mcu_reg_pkg::reg_req_t`: register request type (addr, write, wdata, wstrb, valid).
- `reg_rsp_t`, `core_v_mcu_reg_pkg::reg_resp_t`: register response type (rdata, error, ready).
- `clk_i`  in  1  single clock; everything is synchronous to its rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `reg_req_i`  in  reg_req_t  register request.
- `reg_rsp_o`  out  reg_rsp_t  register response.
- `intr_src_i`  in  NumSources  raw sources, already synchronous to `clk_i`.
- `fast_intr_o`  out  NumSources  per-line request: pending & enable & ~in_service.
- `irq_o`  out  1  the best eligible source has priority > threshold.
- `irq_id_o`  out  $clog2(NumSources+1)  source index + 1 of the winner; 0 = none.

## Operation
- Word-aligned register map, byte offsets; bits at or above NumSources read 0 and ignore writes:
  - 0x00 PENDING: RO for level sources; W1C for edge sources.
  - 0x04 ENABLE: RW, reset 0.
  - 0x08 MODE: RW, 1 = edge, 0 = level, reset 0.
  - 0x0C THRESHOLD: RW [PrioWidth-1:0], reset 0.
  - 0x10 CLAIM: RO. A read returns the current `irq_id_o`. If nonzero, the read sets `in_service[id-1]` and, for an edge source, clears `pending[id-1]`.
  - 0x14 COMPLETE: WO. Writing ID clears `in_service[ID-1]`; ID 0 or ID > NumSources is ignored.
  - 0x18 INSERVICE: RO.
  - 0x40 + 4*i PRIO[i]: RW [PrioWidth-1:0], reset 0.
- Pending update:
  - Level mode: `pending` is a registered copy of `intr_src_i`.
  - Edge mode: `pending` is set on the rising edge `intr_src_i & ~src_q`.
- Eligible source: pending & enable & ~in_service & PRIO > 0.
- Arbitration:
  - The winner is the eligible source with the highest PRIO; a tie goes to the lowest index.
  - `irq_o` = winner exists and PRIO[winner] > THRESHOLD.
  - `irq_id_o` = winner + 1 when `irq_o` is high, else 0.
- Errors: an unmapped address, a write to an RO register, or a read of COMPLETE sets `error = 1`, with no state change and rdata 0.
- Simultaneous events, same cycle:
  - Edge set vs W1C or claim clear of the same bit: the set wins and pending stays 1.
  - COMPLETE and CLAIM target different registers, so they cannot collide.
  - A MODE change takes effect on the next cycle, and `src_q` is always updated, so switching mode never creates a spurious edge.

## Timing
- `reg_rsp_o.ready` = `reg_req_i.valid`: zero wait states. rdata and error are combinational in the request cycle.
- Register writes take effect at the rising edge that ends the request cycle.
- Source latency, measured from `intr_src_i` first sampled high at edge k:
  - `pending` is 1 after edge k.
  - `fast_intr_o`, `irq_o` and `irq_id_o` are registered and update after edge k+1, so latency is 2 cycles.
- A CLAIM read at cycle c removes that source from arbitration; `irq_o`/`irq_id_o` reflect the next winner after edge c+1.
- Reset, including mid-operation:
  - All registers, `pending`, `in_service` and `src_q` go to 0.
  - `irq_o`, `irq_id_o` and `fast_intr_o` are 0.
  - `reg_rsp_o` = {rdata 0, error 0, ready = valid}.

## Structure
- Package `prio_intr_ctrl_pkg`: register offset localparams, the 32-source maximum, and the `IdWidth` helper function.
- Sub-module `prio_intr_arbiter`: a combinational binary comparison tree over {valid, prio, idx}. It returns the winning index, priority and valid, parametrised by `NumSources` and `PrioWidth`.
- Top-level instance name: `u_prio_intr_ctrl`, on a new `*_REG_IDX` slot.

## Test plan
- Level source 3, ENABLE = 0x8, PRIO[3] = 2, THRESHOLD = 1; drive src[3] = 1 → `irq_o` = 1, `irq_id_o` = 4 two cycles later. Drop the source → 0 two cycles later.
- Edge sources 1 and 5 pulse in the same cycle with PRIO 4 and 4 → `irq_id_o` = 2. CLAIM returns 2, then `irq_id_o` = 6. CLAIM returns 6, then `irq_o` = 0. COMPLETE 2 and 6 → INSERVICE = 0.
- PRIO[0] = 3, THRESHOLD = 3 → `irq_o` = 0 while PENDING[0] = 1. Set THRESHOLD = 2 → `irq_o` = 1.
- Edge on source 7 in the same cycle as a W1C of PENDING bit 7 → PENDING[7] stays 1.
- Write to 0x00 for a level bit, write to 0x10, and read at 0x3C → error = 1, with state unchanged.
- Assert `rst_ni` low with 3 sources in service and pending → every output is 0 immediately (asynchronously), and registers read 0 after release.
